// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, op decode helpers.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // op[1] selects divide, op[0] selects unsigned
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative datapath: one shift-add (multiply) or restoring-subtract (divide) step per cycle
// on unsigned magnitudes, held in a 2*WIDTH accumulator.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic [2*WIDTH-1:0] acc_step
);

  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opb_q;
  logic               is_div_q;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   diff;

  // Next accumulator value after one iteration; the top also uses it for the final fix-up.
  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits shifting into quotient bits}.
  always_comb begin
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    // rem_sh >= divisor implies the true difference fits in WIDTH bits
    diff   = rem_sh[WIDTH-1:0] - opb_q;
    if (is_div_q) begin
      if (rem_sh >= {1'b0, opb_q}) begin
        acc_step = {diff, acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step = {sum, acc_q[WIDTH-1:1]};
    end
  end

  // Accumulator and latched operand: loaded on accept, stepped each RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
    end else if (load) begin
      acc_q    <= {{WIDTH{1'b0}}, opa};
      opb_q    <= opb;
      is_div_q <= is_div;
    end else if (step) begin
      acc_q    <= acc_step;
    end
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit top: FSM, iteration counter, sign fix-up and the HI/LO result registers.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [OP_W-1:0]    op_q;
  logic               neg_a_q, neg_b_q, b_zero_q;
  logic [WIDTH-1:0]   a_q;
  logic               busy_q, done_q, dbz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               accept, in_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc_step, prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               res_dbz;

  // Accept decode and operand magnitudes; most-negative maps to 2^(WIDTH-1), which fits unsigned.
  always_comb begin
    accept    = start && (state_q != RUN);
    in_signed = op_is_signed(op);
    mag_a     = (in_signed && a[WIDTH-1]) ? -a : a;
    mag_b     = (in_signed && b[WIDTH-1]) ? -b : b;
  end

  mdu_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .step     (state_q == RUN),
    .is_div   (op_is_div(op)),
    .opa      (mag_a),
    .opb      (mag_b),
    .acc_step (acc_step)
  );

  // Sign fix-up of the final iteration result, committed on the RUN->DONE edge.
  always_comb begin
    prod    = (neg_a_q ^ neg_b_q) ? -acc_step : acc_step;
    quo     = (neg_a_q ^ neg_b_q) ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    rem     = neg_a_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
    res_dbz = 1'b0;
    if (op_is_div(op_q)) begin
      if (b_zero_q) begin
        res_hi  = a_q;
        res_lo  = '1;
        res_dbz = 1'b1;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_zero_q <= 1'b0;
      a_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            dbz_q   <= res_dbz;
          end
        end
        IDLE, DONE: begin
          if (accept) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            op_q     <= op;
            neg_a_q  <= in_signed && a[WIDTH-1];
            neg_b_q  <= in_signed && b[WIDTH-1];
            b_zero_q <= (b == '0);
            a_q      <= a;
            dbz_q    <= 1'b0;
          end else begin
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Parameters
REQ-001 WIDTH, default 32: operand and HI/LO register width in bits; legal values are 8 to 64, even.
REQ-002 OP_W, default 2: width of the op field; fixed at 2 for this generation.

Interface
REQ-003 clk  input  1  sole clock; every register updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request a new operation; sampled only while busy=0.
REQ-006 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 a  input  WIDTH  operand A, the dividend for divide operations.
REQ-008 b  input  WIDTH  operand B, the divisor for divide operations.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse that marks the cycle hi/lo take the new result.
REQ-011 hi  output  WIDTH  HI register: upper product half, or remainder.
REQ-012 lo  output  WIDTH  LO register: lower product half, or quotient.
REQ-013 div_by_zero  output  1  sticky status of the last operation; high when the last divide had b=0.

Function
REQ-014 The FSM SHALL have three states, IDLE, RUN and DONE, and leave IDLE only on the rising edge where start=1.
REQ-015 On accept: a, b and op latched; busy=1 from the next cycle; input changes during RUN ignored.
REQ-016 RUN SHALL last exactly WIDTH cycles, one iteration per cycle: shift-add for multiply, restoring subtract for divide.
REQ-017 After RUN, DONE for one cycle: done=1, busy=0, hi/lo visible; accept-to-done latency is WIDTH+1 cycles.
REQ-018 start=1 in DONE SHALL be accepted (back-to-back), so the next done follows WIDTH+1 cycles later.
REQ-019 start=1 while busy=1 SHALL be ignored, with no queueing and no error flag.
REQ-020 hi and lo SHALL hold their value between done pulses; partial results are never visible on hi or lo.
REQ-021 MULT/MULTU: {hi,lo} SHALL equal the full 2*WIDTH-bit product; MULT treats operands as two's complement, MULTU as unsigned.
REQ-022 DIV/DIVU: lo = quotient, hi = remainder.
REQ-023 DIV rounding: quotient truncates toward zero; remainder takes the dividend's sign; |remainder| < |divisor|.
REQ-024 Signed operations SHALL run on magnitudes, then negate the results as needed in the DONE transition.
REQ-025 Divide by zero SHALL keep the normal latency and give lo = all ones, hi = a, div_by_zero=1.
REQ-026 div_by_zero SHALL clear on the next accepted operation.
REQ-027 DIV with a = most-negative and b = -1 SHALL give lo = most-negative, hi = 0, div_by_zero=0.
REQ-028 Multiply of zero SHALL still take the full WIDTH cycles; there is no early termination in this generation.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, regardless of clk.
REQ-030 Reset during RUN SHALL abandon the operation; no done pulse occurs for it.
REQ-031 The first start after rst_n rises is accepted on the first rising edge where start=1.

Structure
REQ-032 A shared package SHALL hold the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the state enum (IDLE, RUN, DONE).
REQ-033 One sub-module, mdu_iter, SHALL hold the datapath.
REQ-034 mdu_iter SHALL contain the per-cycle shift-add / restore-subtract step and the 2*WIDTH accumulator.
REQ-035 The top level SHALL contain the FSM, the cycle counter ($clog2(WIDTH)+1 bits), the sign fix-up, and the hi/lo registers.

Verification
REQ-036 WIDTH=32, MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF -> done 33 cycles after accept; hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 MULT, a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
REQ-038 DIV, a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU, a=7, b=0 -> lo=0xFFFFFFFF, hi=7, div_by_zero=1.
REQ-039 start held high for 40 cycles -> accepts occur every 33 cycles; pulses during RUN are ignored; a/b changes during RUN do not alter the result.
REQ-040 rst_n low at cycle 10 of RUN -> busy=0, hi=lo=0 immediately; no done pulse follows.
REQ-041 WIDTH=8, DIV, a=0x80, b=0xFF -> lo=0x80, hi=0x00; done 9 cycles after accept.
